axi_rr_arbiter: RTL and testbench

//  2-to-1 AXI4-Stream packet arbiter with round-robin fairness.
//  - Merges two upstream stream masters (slave ports 1/2) onto one downstream stream.
//  - A grant is held for a whole packet, i.e. until the TLAST beat completes.
//  - Sits between stream producers and a shared stream consumer.

---
 rtl/axi_rr_arbiter.sv | 114 +++++++++++
 tb/tb_axi_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// 2-to-1 AXI4-Stream packet arbiter: round-robin between two masters, grant held until TLAST.
// Optional AXI_ARB_BACK2BACK_EN re-arbitrates on the TLAST beat instead of taking an idle bubble.
module axi_rr_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              Aclk,
  input  logic              Aresetn,
  output logic              s_axis_tready1,
  output logic              s_axis_tready2,
  input  logic              s_axis_tvalid1,
  input  logic              s_axis_tvalid2,
  input  logic              s_axis_tlast1,
  input  logic              s_axis_tlast2,
  input  logic [DATA_W-1:0] s_axis_tdata1,
  input  logic [DATA_W-1:0] s_axis_tdata2,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata
);

  typedef enum logic [1:0] {StIdle, StGnt1, StGnt2} state_e;

  state_e state_q, state_d;
  // 0: slave 1 served last, 1: slave 2 served last
  logic   last_q, last_d;
  logic   xfer_last;

  always_comb begin
    s_axis_tready1 = 1'b0;
    s_axis_tready2 = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tdata   = '0;
    unique case (state_q)
      StGnt1: begin
        m_axis_tvalid  = s_axis_tvalid1;
        m_axis_tlast   = s_axis_tlast1;
        m_axis_tdata   = s_axis_tdata1;
        s_axis_tready1 = m_axis_tready;
      end
      StGnt2: begin
        m_axis_tvalid  = s_axis_tvalid2;
        m_axis_tlast   = s_axis_tlast2;
        m_axis_tdata   = s_axis_tdata2;
        s_axis_tready2 = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign xfer_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid1 && s_axis_tvalid2) begin
          state_d = last_q ? StGnt1 : StGnt2;
        end else if (s_axis_tvalid1) begin
          state_d = StGnt1;
        end else if (s_axis_tvalid2) begin
          state_d = StGnt2;
        end
      end
      StGnt1: begin
        if (xfer_last) begin
          last_d = 1'b0;
`ifdef AXI_ARB_BACK2BACK_EN
          if (s_axis_tvalid2) begin
            state_d = StGnt2;
          end else if (s_axis_tvalid1) begin
            state_d = StGnt1;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      StGnt2: begin
        if (xfer_last) begin
          last_d = 1'b1;
`ifdef AXI_ARB_BACK2BACK_EN
          if (s_axis_tvalid1) begin
            state_d = StGnt1;
          end else if (s_axis_tvalid2) begin
            state_d = StGnt2;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Aresetn is an active-high synchronous reset despite its name
  always_ff @(posedge Aclk) begin
    if (Aresetn) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Self-checking bench for axi_rr_arbiter: directed scenarios plus random traffic vs a packet-level
// owner/round-robin model.
module tb_axi_rr_arbiter;

  localparam int unsigned DATA_W = 8;

  logic              Aclk;
  logic              rst;
  logic              v1, v2, l1, l2, mr;
  logic [DATA_W-1:0] d1, d2;
  logic              rdy1, rdy2, m_last, m_valid;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W+3:0] obs_v, exp_v;

  int chk_cnt = 0;
  int pass_cnt = 0;
  // Model: which slave owns the output (0 = nobody) and which slave was served most recently
  int own = 0;
  int last_srv = 2;
  logic xfer, xlast;

  axi_rr_arbiter #(.DATA_W(DATA_W)) dut (
    .Aclk          (Aclk),
    .Aresetn       (rst),
    .s_axis_tready1(rdy1),
    .s_axis_tready2(rdy2),
    .s_axis_tvalid1(v1),
    .s_axis_tvalid2(v2),
    .s_axis_tlast1 (l1),
    .s_axis_tlast2 (l2),
    .s_axis_tdata1 (d1),
    .s_axis_tdata2 (d2),
    .m_axis_tready (mr),
    .m_axis_tlast  (m_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tdata  (m_data)
  );

  assign obs_v = {rdy1, rdy2, m_valid, m_last, m_data};

  initial begin
    Aclk = 1'b0;
    forever #5 Aclk = ~Aclk;
  end

  function automatic logic [DATA_W+3:0] model_out();
    if (own == 1) return {mr, 1'b0, v1, l1, d1};
    if (own == 2) return {1'b0, mr, v2, l2, d2};
    return '0;
  endfunction

  task automatic tick();
    logic ov, ol;
    @(posedge Aclk);
    ov = (own == 1) ? v1 : v2;
    ol = (own == 1) ? l1 : l2;
    if (rst) begin
      own = 0;
      last_srv = 2;
    end else if (own == 0) begin
      if (v1 && v2) own = (last_srv == 1) ? 2 : 1;
      else if (v1) own = 1;
      else if (v2) own = 2;
    end else if (ov && mr && ol) begin
      last_srv = own;
`ifdef AXI_ARB_BACK2BACK_EN
      if ((own == 1) ? v2 : v1) own = 3 - own;
      else if (!ov) own = 0;
`else
      own = 0;
`endif
    end
  endtask

  task automatic set_in(input logic a_v1, input logic a_l1, input logic [DATA_W-1:0] a_d1,
                        input logic a_v2, input logic a_l2, input logic [DATA_W-1:0] a_d2,
                        input logic a_mr, input logic a_rst);
    @(negedge Aclk);
    v1 = a_v1; l1 = a_l1; d1 = a_d1;
    v2 = a_v2; l2 = a_l2; d2 = a_d2;
    mr = a_mr; rst = a_rst;
  endtask

  task automatic test_reset();
    v1 = 1'b1; v2 = 1'b1; l1 = 1'b0; l2 = 1'b0; d1 = '1; d2 = '1; mr = 1'b1; rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), 1'($urandom), 1'b1);
      #1;
      chk_cnt++;
      if (obs_v !== '0) $display("FAIL reset cyc%0d: got %h, expected 0", i, obs_v);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_slave1_stall();
    int beats = 0;
    for (int i = 0; i < 40 && beats < 6; i++) begin
      set_in(1'b1, beats == 5, 8'($urandom), 1'b0, 1'($urandom), 8'($urandom), i >= 3, 1'b0);
      #1;
      exp_v = model_out();
      chk_cnt++;
      if (obs_v !== exp_v) $display("FAIL slave1 cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      else pass_cnt++;
      if (own == 1 && mr) beats++;
      tick();
    end
    chk_cnt++;
    if (beats != 6) $display("FAIL slave1_beats: got %0d, expected 6", beats);
    else pass_cnt++;
    set_in(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0);
    #1;
    exp_v = model_out();
    chk_cnt++;
    if (obs_v !== exp_v) $display("FAIL slave1_after: got %h, expected %h", obs_v, exp_v);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_slave2();
    int beats = 0;
    for (int i = 0; i < 20 && beats < 6; i++) begin
      set_in(1'b0, 1'($urandom), 8'($urandom), 1'b1, beats == 5, 8'(31 + 4 * beats), 1'b1, 1'b0);
      #1;
      exp_v = model_out();
      chk_cnt++;
      if (obs_v !== exp_v) $display("FAIL slave2 cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      else pass_cnt++;
      if (own == 2) beats++;
      tick();
    end
    chk_cnt++;
    if (beats != 6) $display("FAIL slave2_beats: got %0d, expected 6", beats);
    else pass_cnt++;
    set_in(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 8'($urandom), 1'b1, 1'b0);
    #1;
    exp_v = model_out();
    chk_cnt++;
    if (obs_v !== exp_v) $display("FAIL slave2_after: got %h, expected %h", obs_v, exp_v);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_fairness();
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] obs_q[$];
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
      #1;
      exp_v = model_out();
      chk_cnt++;
      if (obs_v !== exp_v) $display("FAIL fair cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      else pass_cnt++;
      if (own != 0) exp_q.push_back((own == 1) ? 8'h11 : 8'h22);
      if (m_valid && mr) obs_q.push_back(m_data);
      tick();
    end
    chk_cnt++;
    if (obs_q != exp_q || exp_q.size() < 2)
      $display("FAIL fair_order: got %p, expected %p", obs_q, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_mid_stall();
    logic mr_pat [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int beats = 0;
    set_in(1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 12 && beats < 4; i++) begin
      // slave 1 drops tvalid in cycle 5 while slave 2 waits: no preemption expected
      set_in(i != 5, beats == 3, 8'($urandom), 1'b1, 1'($urandom), 8'($urandom), mr_pat[i], 1'b0);
      #1;
      exp_v = model_out();
      chk_cnt++;
      if (obs_v !== exp_v) $display("FAIL stall cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      else pass_cnt++;
      if (own == 1 && v1 && mr) beats++;
      tick();
    end
    chk_cnt++;
    if (beats != 4) $display("FAIL stall_beats: got %0d, expected 4", beats);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    set_in(1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_in(i >= 3, 1'b0, 8'($urandom), 1'b1, 1'b0, 8'($urandom), 1'b1, i == 3);
      #1;
      exp_v = model_out();
      chk_cnt++;
      if (obs_v !== exp_v) $display("FAIL midrst cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      else pass_cnt++;
      if (i == 4) begin
        chk_cnt++;
        if (obs_v !== '0) $display("FAIL midrst_idle: got %h, expected 0", obs_v);
        else pass_cnt++;
      end
      if (i == 5) begin
        chk_cnt++;
        if ({rdy1, rdy2, m_data} !== {1'b1, 1'b0, d1})
          $display("FAIL midrst_first: got %b%b %h, expected 10 %h", rdy1, rdy2, m_data, d1);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(3) != 0, $urandom_range(3) == 0, 8'($urandom),
             $urandom_range(2) != 0, $urandom_range(3) == 0, 8'($urandom),
             $urandom_range(3) != 0, $urandom_range(63) == 0);
      #1;
      exp_v = model_out();
      chk_cnt++;
      if (obs_v !== exp_v) $display("FAIL random cyc%0d: got %h, expected %h", i, obs_v, exp_v);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_slave1_stall();
    test_slave2();
    test_fairness();
    test_mid_stall();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
